vc_to_dest_arbiter: RTL and testbench

Transmit-side stage between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1).
- Pops one word per cycle from an eligible VC FIFO and routes it by its destination bit to D0 or D1.
- Throttles on the destination almost-full flags and runs the tx control FSM (RESET/INIT/IDLE/ACTIVE/ERROR).
- VC FIFOs are show-ahead: head word valid whenever not empty. D FIFOs accept one push per cycle.

---
 rtl/vc_to_dest_arbiter.sv | 128 ++++++++++++
 tb/tb_vc_to_dest_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_to_dest_arbiter.sv
// Transmit-side arbiter: pops VC0/VC1 show-ahead FIFOs and routes each word to D0/D1 by its destination bit.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of strict VC0 priority.
module vc_to_dest_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  init,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic                  vc0_empty,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  vc1_empty,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    input  logic                  d0_full,
    input  logic                  d1_full,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic [2:0]            state,
    output logic                  idle,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic                  elig0, elig1;
    logic                  grant0, grant1;
    logic                  can_pop, pop_any, pop_dest;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] pop_data;

    // A head word is only eligible if its own destination has headroom.
    assign elig0 = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    assign elig1 = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

`ifdef ARB_RR_EN
    // Remembers which VC won the last pop (1 = VC1), so VC0 wins the first contest.
    logic last_grant;

    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && !grant0;

    always_ff @(posedge clk) begin
        if (!RESET_L)
            last_grant <= 1'b1;
        else if (pop_any)
            last_grant <= pop_vc1;
    end
`else
    assign grant0 = elig0;
    assign grant1 = elig1 && !elig0;
`endif

    assign can_pop  = (state_q == ST_ACTIVE) && !init;
    assign pop_vc0  = can_pop && grant0;
    assign pop_vc1  = can_pop && grant1;
    assign pop_any  = pop_vc0 || pop_vc1;
    assign pop_data = pop_vc0 ? vc0_data : vc1_data;
    assign pop_dest = pop_data[DEST_BIT];

    // The push stage runs independently of the FSM so an in-flight word always lands.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_L) begin
            push_d0 <= 1'b0;
            push_d1 <= 1'b0;
            d_data  <= '0;
        end else begin
            push_d0 <= pop_any && !pop_dest;
            push_d1 <= pop_any && pop_dest;
            if (pop_any)
                d_data <= pop_data;
        end
    end

    assign overflow = (push_d0 && d0_full) || (push_d1 && d1_full);

    always_ff @(posedge clk) begin
        if (!RESET_L)
            state_q <= ST_RESET;
        else
            state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_d = state_q;
        if (overflow) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   if (!init) state_d = ST_IDLE;
                ST_IDLE: begin
                    if (init)
                        state_d = ST_INIT;
                    else if (!vc0_empty || !vc1_empty)
                        state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (init)
                        state_d = ST_INIT;
                    else if (vc0_empty && vc1_empty && !push_d0 && !push_d1)
                        state_d = ST_IDLE;
                end
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_ERROR;
            endcase
        end
    end

    assign state = state_q;
    assign idle  = (state_q == ST_IDLE);
    assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_vc_to_dest_arbiter.sv
// Directed self-checking bench for vc_to_dest_arbiter; expected values are hand-computed per step.
module tb_vc_to_dest_arbiter;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          RESET_L;
    logic          init;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          vc0_empty, vc1_empty;
    logic          d0_almost_full, d1_almost_full, d0_full, d1_full;
    logic          pop_vc0, pop_vc1, push_d0, push_d1;
    logic [DW-1:0] d_data;
    logic [2:0]    state;
    logic          idle, error;

    int checks = 0;
    int errors = 0;

    vc_to_dest_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(4)) dut (
        .clk(clk), .RESET_L(RESET_L), .init(init),
        .vc0_data(vc0_data), .vc0_empty(vc0_empty),
        .vc1_data(vc1_data), .vc1_empty(vc1_empty),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .d0_full(d0_full), .d1_full(d1_full),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1), .d_data(d_data),
        .state(state), .idle(idle), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_no_pop(input string tag);
        check({tag, "_pop0"}, {31'd0, pop_vc0}, 32'd0);
        check({tag, "_pop1"}, {31'd0, pop_vc1}, 32'd0);
    endtask

    logic [DW-1:0] w0 [3];
    logic [DW-1:0] w1 [3];
    logic          ord [6];

    initial begin
        int i0;
        int i1;
        logic [DW-1:0] exp_word;

        w0[0] = 6'h10; w0[1] = 6'h14; w0[2] = 6'h1A;
        w1[0] = 6'h31; w1[1] = 6'h35; w1[2] = 6'h3F;
`ifdef ARB_RR_EN
        ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1; ord[4] = 0; ord[5] = 1;
`else
        ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 1; ord[4] = 1; ord[5] = 1;
`endif

        RESET_L = 1'b0; init = 1'b1;
        vc0_data = '0; vc1_data = '0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0; d0_full = 1'b0; d1_full = 1'b0;

        // Reset and init sequence: 0,0,1,1,1,2
        tick();
        check("rst_state0", {29'd0, state}, 32'd0);
        check("rst_push_d0", {31'd0, push_d0}, 32'd0);
        check("rst_push_d1", {31'd0, push_d1}, 32'd0);
        check("rst_d_data", {26'd0, d_data}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd0);
        check_no_pop("rst");
        tick();
        check("rst_state1", {29'd0, state}, 32'd0);
        RESET_L = 1'b1;
        tick();
        check("init_state0", {29'd0, state}, 32'd1);
        tick();
        check("init_state1", {29'd0, state}, 32'd1);
        tick();
        check("init_state2", {29'd0, state}, 32'd1);
        check_no_pop("init");
        check("init_push_d0", {31'd0, push_d0}, 32'd0);
        init = 1'b0;
        tick();
        check("idle_state", {29'd0, state}, 32'd2);
        check("idle_flag", {31'd0, idle}, 32'd1);

        // Arbitration order: three words per VC, all destined to D1
        i0 = 0; i1 = 0;
        vc0_data = w0[0]; vc1_data = w1[0]; vc0_empty = 1'b0; vc1_empty = 1'b0;
        settle();
        check_no_pop("arb_idle");
        tick();
        check("arb_active", {29'd0, state}, 32'd3);
        for (int k = 0; k < 6; k++) begin
            settle();
            check("arb_pop0", {31'd0, pop_vc0}, {31'd0, !ord[k]});
            check("arb_pop1", {31'd0, pop_vc1}, {31'd0, ord[k]});
            exp_word = ord[k] ? w1[i1] : w0[i0];
            tick();
            check("arb_push_d1", {31'd0, push_d1}, 32'd1);
            check("arb_push_d0", {31'd0, push_d0}, 32'd0);
            check("arb_data", {26'd0, d_data}, {26'd0, exp_word});
            if (ord[k]) begin
                i1++;
                if (i1 == 3) vc1_empty = 1'b1; else vc1_data = w1[i1];
            end else begin
                i0++;
                if (i0 == 3) vc0_empty = 1'b1; else vc0_data = w0[i0];
            end
        end
        tick();
        check("arb_drain_state", {29'd0, state}, 32'd3);
        tick();
        check("arb_back_idle", {29'd0, state}, 32'd2);

        // Basic routing: 6'h05 to D0 and 6'h13 to D1
        vc0_data = 6'h05; vc0_empty = 1'b0; vc1_data = 6'h13; vc1_empty = 1'b0;
        settle();
        check_no_pop("route_idle");
        tick();
        check("route_active", {29'd0, state}, 32'd3);
        settle();
        check("route_pop0", {31'd0, pop_vc0}, 32'd1);
        check("route_pop1_blocked", {31'd0, pop_vc1}, 32'd0);
        tick();
        check("route_push_d0", {31'd0, push_d0}, 32'd1);
        check("route_push_d1_low", {31'd0, push_d1}, 32'd0);
        check("route_data0", {26'd0, d_data}, 32'h05);
        vc0_empty = 1'b1;
        settle();
        check("route_pop1", {31'd0, pop_vc1}, 32'd1);
        tick();
        check("route_push_d1", {31'd0, push_d1}, 32'd1);
        check("route_push_d0_low", {31'd0, push_d0}, 32'd0);
        check("route_data1", {26'd0, d_data}, 32'h13);
        vc1_empty = 1'b1;
        settle();
        check_no_pop("route_empty");
        tick();
        check("route_inflight_state", {29'd0, state}, 32'd3);
        check("route_push_clear", {31'd0, push_d1}, 32'd0);
        check("route_data_hold", {26'd0, d_data}, 32'h13);
        tick();
        check("route_back_idle", {29'd0, state}, 32'd2);

        // Backpressure on D0 does not block VC1
        d0_almost_full = 1'b1;
        vc0_data = 6'h02; vc0_empty = 1'b0; vc1_data = 6'h11; vc1_empty = 1'b0;
        tick();
        check("bp_active", {29'd0, state}, 32'd3);
        settle();
        check("bp_pop0_blocked", {31'd0, pop_vc0}, 32'd0);
        check("bp_pop1", {31'd0, pop_vc1}, 32'd1);
        tick();
        check("bp_push_d1", {31'd0, push_d1}, 32'd1);
        check("bp_data", {26'd0, d_data}, 32'h11);
        vc1_empty = 1'b1;
        settle();
        check_no_pop("bp_held");
        tick();
        check("bp_state_held", {29'd0, state}, 32'd3);
        check("bp_pop0_still", {31'd0, pop_vc0}, 32'd0);
        d0_almost_full = 1'b0;
        settle();
        check("bp_pop0_release", {31'd0, pop_vc0}, 32'd1);
        tick();
        check("bp_push_d0", {31'd0, push_d0}, 32'd1);
        check("bp_data0", {26'd0, d_data}, 32'h02);
        vc0_empty = 1'b1;
        tick();
        tick();
        check("bp_back_idle", {29'd0, state}, 32'd2);

        // Push into a full D1 forces ERROR until reset
        vc1_data = 6'h13; vc1_empty = 1'b0;
        tick();
        settle();
        check("err_pop1", {31'd0, pop_vc1}, 32'd1);
        tick();
        check("err_push_d1", {31'd0, push_d1}, 32'd1);
        d1_full = 1'b1; vc1_empty = 1'b1;
        tick();
        check("err_state", {29'd0, state}, 32'd4);
        check("err_flag", {31'd0, error}, 32'd1);
        check("err_idle", {31'd0, idle}, 32'd0);
        d1_full = 1'b0; vc0_data = 6'h07; vc0_empty = 1'b0;
        settle();
        check_no_pop("err_hold");
        tick();
        check("err_sticky", {29'd0, state}, 32'd4);
        check("err_no_push", {31'd0, push_d0}, 32'd0);
        RESET_L = 1'b0;
        tick();
        check("err_rst_state", {29'd0, state}, 32'd0);
        check("err_rst_flag", {31'd0, error}, 32'd0);
        check("err_rst_data", {26'd0, d_data}, 32'd0);
        RESET_L = 1'b1; init = 1'b0;
        tick();
        check("re_init", {29'd0, state}, 32'd1);
        check_no_pop("re_init");
        tick();
        check("re_idle", {29'd0, state}, 32'd2);

        // init raised right after a pop: the in-flight word still lands
        tick();
        check("mid_active", {29'd0, state}, 32'd3);
        settle();
        check("mid_pop0", {31'd0, pop_vc0}, 32'd1);
        tick();
        vc0_data = 6'h08;
        init = 1'b1;
        settle();
        check("mid_push_d0", {31'd0, push_d0}, 32'd1);
        check("mid_data", {26'd0, d_data}, 32'h07);
        check("mid_pop_gated", {31'd0, pop_vc0}, 32'd0);
        tick();
        check("mid_state_init", {29'd0, state}, 32'd1);
        check("mid_push_done", {31'd0, push_d0}, 32'd0);
        check_no_pop("mid_init");
        init = 1'b0;
        tick();
        check("mid_idle", {29'd0, state}, 32'd2);
        tick();
        check("mid_reactive", {29'd0, state}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
